prefetch_unit: RTL

//  Parametrised pipeline front end. Decouples instruction memory latency from decode with a DEPTH-entry prefetch queue.

---
 rtl/prefetch_unit_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/prefetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/prefetch_unit_pkg.sv
// Shared definitions for the prefetch front end.
// Architecture macros get defaults here when no shared header supplies them.
// Optional feature macro used by this slice: PREFETCH_PERF_EN (performance counters).
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif
`ifndef NOP_INST
`define NOP_INST 32'h0000_0013
`endif
`ifndef PREFETCH_DEPTH
`define PREFETCH_DEPTH 4
`endif

package prefetch_unit_pkg;

    // Width of the performance counters.
    localparam int unsigned PERF_W = 32;

    // Bits needed to hold a value in 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush holding {pc, instruction} pairs for the prefetch unit.
// Storage is not reset; only pointers and the occupancy count are.
module fetch_fifo
    import prefetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = cnt_width(DEPTH),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A flush wins over both push and pop; a push into a full queue needs a same-cycle pop.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Next pointer and occupancy values; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch front end: issues in-order fetches ahead of decode, buffers
// responses in a small queue, and drives the registered stage-1 output.
// A jump flushes the queue and drops responses still in flight.
// Optional feature macro: PREFETCH_PERF_EN adds perf_fetch_cnt / perf_drop_cnt.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH    = `PREFETCH_DEPTH,
    parameter int unsigned ADDR_W   = `ADDRESS_SIZE,
    parameter int unsigned INST_W   = `INSTRUCTION_SIZE,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instruction_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              valid_out
`ifdef PREFETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_fetch_cnt,
    output logic [PERF_W-1:0] perf_drop_cnt
`endif
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam logic [INST_W-1:0] NOP = INST_W'(`NOP_INST);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [INST_W-1:0] inst_out_q, inst_out_d;
    logic              valid_out_q, valid_out_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic [CNT_W-1:0]         fifo_cnt;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [ADDR_W+INST_W-1:0] fifo_rdata;
    logic [CNT_W:0]           in_flight;
    logic                     hold;
    logic                     jump_take;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     rsp_discard;

    // Halt/stall freeze the output stage, so a jump is only taken when neither is set.
    assign hold      = halt || stall;
    assign jump_take = jump && !hold;
    assign in_flight = {1'b0, fifo_cnt} + {1'b0, outstanding_q};
    assign imem_req  = !halt && !jump && (in_flight < (CNT_W+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;

    // A response is kept only when nothing remains to be dropped and no flush happens this cycle.
    assign rsp_discard = imem_rvalid && ((drop_q != '0) || jump_take);
    assign push        = imem_rvalid && (drop_q == '0) && !jump_take;
    assign pop         = !hold && !jump_take && !fifo_empty;

    assign instruction_out = inst_out_q;
    assign pc_out          = pc_out_q;
    assign valid_out       = valid_out_q;

    fetch_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (jump_take),
        .wdata ({resp_pc_q, imem_rdata}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Next-state for fetch/response PCs, in-flight bookkeeping and the stage-1 output.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        pc_out_d      = pc_out_q;
        inst_out_d    = inst_out_q;
        valid_out_d   = valid_out_q;
        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(imem_rvalid);
        drop_d        = drop_q;

        if (jump_take) begin
            fetch_pc_d = jump_pc;
            resp_pc_d  = jump_pc;
            // Everything still in flight after this cycle belongs to the old path.
            drop_d     = outstanding_q - CNT_W'(imem_rvalid);
        end else begin
            if (issue)                            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            if (push)                             resp_pc_d  = resp_pc_q + ADDR_W'(1);
            if (imem_rvalid && (drop_q != '0))    drop_d     = drop_q - CNT_W'(1);
        end

        if (hold) begin
            pc_out_d    = pc_out_q;
            inst_out_d  = inst_out_q;
            valid_out_d = valid_out_q;
        end else if (jump_take) begin
            pc_out_d    = jump_pc;
            inst_out_d  = NOP;
            valid_out_d = 1'b0;
        end else if (!fifo_empty) begin
            pc_out_d    = fifo_rdata[ADDR_W+INST_W-1:INST_W];
            inst_out_d  = fifo_rdata[INST_W-1:0];
            valid_out_d = 1'b1;
        end else begin
            inst_out_d  = NOP;
            valid_out_d = 1'b0;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            pc_out_q      <= RESET_PC;
            inst_out_q    <= NOP;
            valid_out_q   <= 1'b0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            pc_out_q      <= pc_out_d;
            inst_out_q    <= inst_out_d;
            valid_out_q   <= valid_out_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

`ifdef PREFETCH_PERF_EN
    logic [PERF_W-1:0] perf_fetch_q, perf_fetch_d;
    logic [PERF_W-1:0] perf_drop_q, perf_drop_d;

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;

    // Count granted fetches, and discarded responses plus entries lost to a flush.
    always_comb begin
        perf_fetch_d = perf_fetch_q + PERF_W'(issue);
        perf_drop_d  = perf_drop_q + PERF_W'(rsp_discard)
                     + (jump_take ? PERF_W'(fifo_cnt) : '0);
    end

    // Performance counter registers; wrap freely.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
        end
    end
`endif

`ifndef SYNTHESIS
    // Memory must not answer a request that was never issued.
    a_rvalid_with_outstanding: assert property (@(posedge clock) disable iff (!reset)
        !(imem_rvalid && (outstanding_q == '0)))
        else $error("prefetch_unit: imem_rvalid with no request outstanding");

    // Memory must not grant a request that is not being made.
    a_gnt_with_req: assert property (@(posedge clock) disable iff (!reset)
        !(imem_gnt && !imem_req))
        else $error("prefetch_unit: imem_gnt without imem_req");

    // The in-flight bound guarantees a kept response always finds room.
    a_push_fits: assert property (@(posedge clock) disable iff (!reset)
        !(push && fifo_full && !pop))
        else $error("prefetch_unit: response pushed into a full queue");
`endif

endmodule
